// File: rtl/life_grid_store.sv
`default_nettype none
// ============================================================================
// Module   : life_grid_store
// Brief    : Rotating multi-lane Life cell store with command FSM, cursor
//            edits, generation and population counters.
// Revision : 1.0  initial release
// ============================================================================
module life_grid_store #(
  parameter int          X         = 8,
  parameter int          Y         = 8,
  parameter int          LOG2X     = 3,
  parameter int          LOG2Y     = 3,
  parameter int          LANES     = 1,
  parameter int          WB_OFFSET = X*(Y-1)-3,
  parameter int          GEN_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2024,
  localparam int         IDX_W     = $clog2(X*Y)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [2:0]       cmd,
  output logic             cmd_ready,
  input  logic             edit_valid,
  input  logic [1:0]       edit_op,
  input  logic [LOG2X-1:0] edit_x,
  input  logic [LOG2Y-1:0] edit_y,
  output logic             edit_ready,
  input  logic [LANES-1:0] pipe_cells,
  output logic [LANES-1:0] head_cells,
  output logic [IDX_W-1:0] head_idx,
  output logic             frame_start,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic [IDX_W:0]   pop_count
);

  localparam int N      = X*Y;
  localparam int FRAMES = N/LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [IDX_W-1:0] C_LAST_HEAD = IDX_W'(N-LANES);
  localparam logic [CNT_W-1:0] C_LAST_CNT  = CNT_W'(FRAMES-1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_GEN   = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_FILL  = 3'd4;

  localparam logic [2:0] C_RUN    = 3'd1;
  localparam logic [2:0] C_STOP   = 3'd2;
  localparam logic [2:0] C_STEP   = 3'd3;
  localparam logic [2:0] C_CLEAR  = 3'd4;
  localparam logic [2:0] C_RANDOM = 3'd5;

  logic [N-1:0]       r_buf;
  logic [IDX_W-1:0]   r_head;
  logic [2:0]         r_state, w_next_state;
  logic               r_run;
  logic [GEN_W-1:0]   r_gen;
  logic [IDX_W:0]     r_pop, r_acc, w_head_pop;
  logic [31:0]        r_lfsr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_edit_pend;
  logic [IDX_W-1:0]   r_edit_idx;
  logic [1:0]         r_edit_op;

  logic               w_cmd_fire, w_stop_fire, w_last_head, w_cnt_last;
  logic [31:0]        w_edit_idx;
  logic               w_edit_fire, w_edit_hit;
  logic [LANE_W-1:0]  w_lane;
  logic [LANES-1:0]   w_tail;
  logic [N-1:0]       w_buf_n;

  assign head_cells  = r_buf[LANES-1:0];
  assign head_idx    = r_head;
  assign frame_start = (r_head == '0);
  assign gen_count   = r_gen;
  assign pop_count   = r_pop;
  assign edit_ready  = ~r_edit_pend;

  assign w_cmd_fire  = cmd_valid & cmd_ready;
  assign w_stop_fire = w_cmd_fire & (cmd == C_STOP);
  assign w_last_head = (r_head == C_LAST_HEAD);
  assign w_cnt_last  = (r_cnt == C_LAST_CNT);

  // Out-of-range coordinates are discarded here so they never occupy the slot.
  assign w_edit_idx  = 32'(edit_y) * 32'(X) + 32'(edit_x);
  assign w_edit_fire = edit_valid & ~r_edit_pend & (w_edit_idx < 32'(N));
  assign w_edit_hit  = r_edit_pend & ({1'b0, r_edit_idx} >= {1'b0, r_head}) &
                       ({1'b0, r_edit_idx} < ({1'b0, r_head} + (IDX_W+1)'(LANES)));
  assign w_lane      = LANE_W'(r_edit_idx - r_head);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            C_RUN, C_STEP: w_next_state = w_last_head ? S_GEN : S_ARM;
            C_CLEAR:       w_next_state = S_CLEAR;
            C_RANDOM:      w_next_state = S_FILL;
            default:       w_next_state = S_IDLE;
          endcase
        end
      end
      S_ARM: begin
        if (w_stop_fire)      w_next_state = S_IDLE;
        else if (w_last_head) w_next_state = S_GEN;
      end
      S_GEN: begin
        if (w_last_head) w_next_state = (r_run & ~w_stop_fire) ? S_GEN : S_IDLE;
      end
      S_CLEAR, S_FILL: begin
        if (w_cnt_last) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:       cmd_ready = 1'b1;
      S_ARM, S_GEN: cmd_ready = (cmd == C_STOP);
      default:      cmd_ready = 1'b0;
    endcase
  end

  // Tail source, then pipe writeback, then the cursor edit on top of both.
  always_comb begin
    w_tail = r_buf[LANES-1:0];
    if (r_state == S_CLEAR)     w_tail = '0;
    else if (r_state == S_FILL) w_tail = r_lfsr[LANES-1:0];
    w_buf_n = {w_tail, r_buf[N-1:LANES]};
    if (r_state == S_GEN) w_buf_n[WB_OFFSET +: LANES] = pipe_cells;
    if (w_edit_hit) begin
      case (r_edit_op)
        2'd0:    w_buf_n[N-LANES+int'(w_lane)] = ~w_buf_n[N-LANES+int'(w_lane)];
        2'd1:    w_buf_n[N-LANES+int'(w_lane)] = 1'b1;
        2'd2:    w_buf_n[N-LANES+int'(w_lane)] = 1'b0;
        default: w_buf_n[N-LANES+int'(w_lane)] = w_buf_n[N-LANES+int'(w_lane)];
      endcase
    end
  end

  always_comb begin
    w_head_pop = '0;
    for (int i = 0; i < LANES; i++) w_head_pop = w_head_pop + (IDX_W+1)'(head_cells[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_buf       <= '0;
      r_head      <= '0;
      r_run       <= 1'b0;
      r_gen       <= '0;
      r_pop       <= '0;
      r_acc       <= '0;
      r_lfsr      <= LFSR_SEED;
      r_cnt       <= '0;
      r_edit_pend <= 1'b0;
      r_edit_idx  <= '0;
      r_edit_op   <= 2'd3;
    end else begin
      r_buf  <= w_buf_n;
      r_head <= w_last_head ? '0 : r_head + IDX_W'(LANES);

      if (w_last_head) begin
        r_pop <= r_acc + w_head_pop;
        r_acc <= '0;
      end else begin
        r_acc <= r_acc + w_head_pop;
      end

      if (r_state == S_IDLE && w_cmd_fire && cmd == C_RUN)       r_run <= 1'b1;
      else if (r_state == S_IDLE && w_cmd_fire && cmd == C_STEP) r_run <= 1'b0;
      else if (w_stop_fire)                                      r_run <= 1'b0;

      if (r_state == S_GEN && w_last_head)        r_gen <= r_gen + 1'b1;
      else if (r_state == S_CLEAR && w_cnt_last)  r_gen <= '0;

      r_cnt <= (r_state == S_CLEAR || r_state == S_FILL) ? r_cnt + 1'b1 : '0;

      // Galois form of x^32 + x^22 + x^2 + x + 1, advanced only while filling.
      if (r_state == S_FILL)
        r_lfsr <= r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h8020_0003) : (r_lfsr >> 1);

      if (w_edit_fire) begin
        r_edit_pend <= 1'b1;
        r_edit_idx  <= w_edit_idx[IDX_W-1:0];
        r_edit_op   <= edit_op;
      end else if (w_edit_hit) begin
        r_edit_pend <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_grid_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_grid_store
// Brief    : Directed self-checking bench for life_grid_store (8x8, 2 lanes).
// Revision : 1.0  initial release
// ============================================================================
module tb_life_grid_store;

  localparam logic [31:0] SEED = 32'hACE1_2024;

  logic       clk, reset, cmd_valid, cmd_ready, edit_valid, edit_ready;
  logic [2:0] cmd;
  logic [1:0] edit_op, pipe_cells, head_cells;
  logic [2:0] edit_x, edit_y;
  logic [5:0] head_idx;
  logic       frame_start, busy;
  logic [15:0] gen_count;
  logic [6:0]  pop_count;

  int n_tests, n_fail, exp_head, k;

  life_grid_store #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .LANES(2), .GEN_W(16), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
    .edit_valid(edit_valid), .edit_op(edit_op), .edit_x(edit_x), .edit_y(edit_y),
    .edit_ready(edit_ready),
    .pipe_cells(pipe_cells), .head_cells(head_cells), .head_idx(head_idx),
    .frame_start(frame_start), .busy(busy), .gen_count(gen_count), .pop_count(pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    exp_head = (exp_head + 2) % 64;
    check("head_idx", 64'(head_idx), 64'(exp_head));
    check("frame_start", 64'(frame_start), 64'(exp_head == 0));
  endtask

  task automatic go_to(input int h);
    while (exp_head != h) tick();
  endtask

  function automatic int fill_pop();
    logic [31:0] l;
    int s;
    l = SEED;
    s = 0;
    for (int i = 0; i < 32; i++) begin
      s = s + int'(l[0]) + int'(l[1]);
      l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    end
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; exp_head = 0;
    reset = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; edit_valid = 1'b0; edit_op = 2'd3;
    edit_x = 3'd0; edit_y = 3'd0; pipe_cells = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset state
    check("rst_head_idx", 64'(head_idx), 64'd0);
    check("rst_head_cells", 64'(head_cells), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_pop", 64'(pop_count), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_edit_ready", 64'(edit_ready), 64'd1);
    check("rst_frame_start", 64'(frame_start), 64'd1);

    // Idle rotation over two frames
    for (int i = 0; i < 64; i++) begin
      tick();
      check("idle_head_cells", 64'(head_cells), 64'd0);
    end
    check("idle_pop", 64'(pop_count), 64'd0);

    // Set cell (3,2) = index 19
    edit_valid = 1'b1; edit_op = 2'd1; edit_x = 3'd3; edit_y = 3'd2;
    tick();
    edit_valid = 1'b0;
    check("edit_ready_drop", 64'(edit_ready), 64'd0);
    k = 0;
    while (!edit_ready && k < 40) begin tick(); k++; end
    check("edit_latency_ok", 64'(k <= 32), 64'd1);
    go_to(18);
    check("cell19_head", 64'(head_cells), 64'h2);
    go_to(0);
    check("pop_after_set", 64'(pop_count), 64'd1);

    // Flip the same cell back off
    edit_valid = 1'b1; edit_op = 2'd0;
    tick();
    edit_valid = 1'b0;
    k = 0;
    while (!edit_ready && k < 40) begin tick(); k++; end
    check("flip_latency_ok", 64'(k <= 32), 64'd1);
    go_to(0);
    check("pop_flip_frame", 64'(pop_count), 64'd1);
    repeat (32) tick();
    check("pop_after_flip", 64'(pop_count), 64'd0);

    // STEP issued mid-frame at head 10
    go_to(10);
    cmd_valid = 1'b1; cmd = 3'd3;
    #1 check("step_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; cmd = 3'd0;
    check("arm_busy", 64'(busy), 64'd1);
    cmd = 3'd1;
    #1 check("arm_ready_run", 64'(cmd_ready), 64'd0);
    cmd = 3'd0;
    repeat (26) tick();
    check("gen_start_busy", 64'(busy), 64'd1);
    check("gen_start_count", 64'(gen_count), 64'd0);
    pipe_cells = 2'b11;
    tick();
    pipe_cells = 2'b00;
    go_to(54);
    check("wb_cell55", 64'(head_cells), 64'h2);
    tick();
    check("wb_cell56", 64'(head_cells), 64'h1);
    go_to(62);
    check("gen_last_busy", 64'(busy), 64'd1);
    check("gen_last_count", 64'(gen_count), 64'd0);
    tick();
    check("step_done_busy", 64'(busy), 64'd0);
    check("step_gen_count", 64'(gen_count), 64'd1);
    check("step_pop", 64'(pop_count), 64'd2);

    // RUN from head 62 starts GEN at once; STOP during third frame
    go_to(62);
    cmd_valid = 1'b1; cmd = 3'd1;
    #1 check("run_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; cmd = 3'd5;
    #1 check("gen_ready_random", 64'(cmd_ready), 64'd0);
    cmd = 3'd2;
    #1 check("gen_ready_stop", 64'(cmd_ready), 64'd1);
    cmd = 3'd0;
    check("run_busy", 64'(busy), 64'd1);
    repeat (32) tick();
    check("run_gen1", 64'(gen_count), 64'd2);
    repeat (32) tick();
    check("run_gen2", 64'(gen_count), 64'd3);
    repeat (10) tick();
    cmd_valid = 1'b1; cmd = 3'd2;
    #1 check("stop_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; cmd = 3'd0;
    repeat (20) tick();
    check("stop_frame_busy", 64'(busy), 64'd1);
    check("stop_frame_gen", 64'(gen_count), 64'd3);
    tick();
    check("stop_idle", 64'(busy), 64'd0);
    check("stop_gen", 64'(gen_count), 64'd4);

    // RANDOM fill
    cmd_valid = 1'b1; cmd = 3'd5;
    #1 check("random_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; cmd = 3'd0;
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    check("fill_busy_cycles", 64'(k), 64'd32);
    go_to(0);
    repeat (32) tick();
    check("fill_pop", 64'(pop_count), 64'(fill_pop()));

    // Plain CLEAR
    cmd_valid = 1'b1; cmd = 3'd4;
    #1 check("clear_ready", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0; cmd = 3'd2;
    #1 check("clear_ready_stop", 64'(cmd_ready), 64'd0);
    cmd = 3'd0;
    k = 1;
    while (busy && k < 100) begin tick(); k++; end
    check("clear_busy_cycles", 64'(k - 1), 64'd32);
    check("clear_gen", 64'(gen_count), 64'd0);
    go_to(0);
    repeat (32) tick();
    check("clear_pop", 64'(pop_count), 64'd0);

    // CLEAR with a concurrent set edit at (5,4) = index 37
    cmd_valid = 1'b1; cmd = 3'd4;
    edit_valid = 1'b1; edit_op = 2'd1; edit_x = 3'd5; edit_y = 3'd4;
    tick();
    cmd_valid = 1'b0; cmd = 3'd0; edit_valid = 1'b0;
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    check("clear2_busy_cycles", 64'(k), 64'd32);
    check("clear2_edit_ready", 64'(edit_ready), 64'd1);
    go_to(0);
    repeat (32) tick();
    check("edit_survives_pop", 64'(pop_count), 64'd1);
    go_to(36);
    check("edit_survives_cell", 64'(head_cells), 64'h2);

    // Reset asserted mid-GEN with an edit pending
    go_to(62);
    cmd_valid = 1'b1; cmd = 3'd3;
    tick();
    cmd_valid = 1'b0; cmd = 3'd0; pipe_cells = 2'b11;
    check("gen2_busy", 64'(busy), 64'd1);
    repeat (10) tick();
    edit_valid = 1'b1; edit_op = 2'd0; edit_x = 3'd7; edit_y = 3'd7;
    tick();
    edit_valid = 1'b0;
    check("pend_edit_ready", 64'(edit_ready), 64'd0);
    reset = 1'b0;
    exp_head = 0;
    #1;
    check("mid_rst_head_idx", 64'(head_idx), 64'd0);
    check("mid_rst_head_cells", 64'(head_cells), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_gen", 64'(gen_count), 64'd0);
    check("mid_rst_pop", 64'(pop_count), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_edit_ready", 64'(edit_ready), 64'd1);
    check("mid_rst_frame_start", 64'(frame_start), 64'd1);
    pipe_cells = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("post_rst_head_cells", 64'(head_cells), 64'd0);
    end
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_pop", 64'(pop_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
